mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
- Two-port memory arbiter directly upstream of the CPU's memory model/controller.
- Port 0 is the instruction-fetch requester; port 1 is the data (operand/store) requester.
- Grants one transaction at a time onto the single memory request interface, holds the request until acknowledged, captures read data and returns a one-cycle completion pulse to the winner.
- A programmable ack timeout reports non-existent memory (NXM) instead of hanging.

Parameters:
- ADDR_W, 22, physical address width; equals the design's PADDR width.
- DATA_W, 36, word width; bit 0 is the MSB, matching the WORD convention.
- TIMEOUT, 64, cycles to wait in REQ for a memory ack before declaring NXM; 0 disables the timeout (wait forever). Legal range 0..255.

Ports:
- clk  in  1  single clock, all state on posedge.
- reset  in  1  asynchronous, active-low; 0 forces reset immediately, release is sampled on clk.
- p0_addr  in  ADDR_W  port 0 address, held while request pending.
- p0_wdata  in  DATA_W  port 0 write data, held while request pending.
- p0_read  in  1  port 0 read request, level, held until p0_ack.
- p0_write  in  1  port 0 write request, level, held until p0_ack.
- p0_rdata  out  DATA_W  port 0 read data, valid in the p0_ack cycle, held until next port 0 read completes.
- p0_ack  out  1  one-cycle completion pulse.
- p0_nxm  out  1  high with p0_ack when the transaction timed out.
- p1_addr, p1_wdata, p1_read, p1_write, p1_rdata, p1_ack, p1_nxm: identical set for port 1.
- mem_addr  out  ADDR_W  address to memory.
- mem_write_data  out  DATA_W  write data to memory.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_read_data  in  DATA_W  memory read data, valid the cycle after read_ack is sampled high.
- read_ack  in  1  memory read accepted; may be combinational from mem_read (same cycle).
- write_ack  in  1  memory write done; may be combinational from mem_write.

Behaviour:
- Reset values (while reset=0): state IDLE, all ack/nxm outputs 0, mem_read=0, mem_write=0, rdata outputs 0, mem_addr/mem_write_data 0, timeout counter 0, round-robin pointer favours port 0. A transaction in flight is abandoned; no ack is issued for it.
- States: IDLE, REQ, RDATA, ACK. mem_read/mem_write are high only in REQ; mem_addr, mem_write_data and the operation latch at grant and stay stable through REQ.
- IDLE: sample both ports. No request -> stay. One port requesting -> grant it, go REQ. Both requesting -> grant the port not granted last, go REQ, flip pointer.
- A port with both read and write high is treated as a read; write is ignored.
- REQ: assert mem_read or mem_write.
  - Matching ack sampled high at a posedge -> read: go RDATA; write: go ACK.
  - Immediate ack means exactly one cycle of mem_read/mem_write.
  - The non-matching ack is ignored.
- RDATA: mem_read/mem_write low. At the posedge, capture mem_read_data into the granted port's rdata; go ACK.
- ACK: granted port's ack=1 for exactly one cycle; go IDLE. Requests are not sampled in ACK, so a requester that is still high in its ack cycle is not regranted.
- Latency with zero-wait memory (request first seen high in cycle 0):
  - Read: mem_read in cycle 1, data on mem_read_data in cycle 2, pN_ack/pN_rdata in cycle 3, next grant sampled in cycle 4.
  - Write: mem_write in cycle 1, pN_ack in cycle 2.
- Timeout:
  - Counter clears on entry to REQ and increments each REQ cycle without an ack.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack that cycle -> go ACK with pN_nxm=1. Read rdata is forced to 0. Memory request drops.
  - An ack arriving in the same cycle as expiry wins; no NXM.
- A requester dropping its request while granted is a protocol violation; the arbiter still completes and acks the transaction.
- The ungranted port's ack/nxm stay 0; its rdata holds its previous value.

Test Plan:
- Reset mid-read (reset low while in REQ) -> mem_read falls immediately, no p0_ack; after release, a fresh p0_read of 0o001000 completes normally.
- Port 0 read of 0o000100 (memory word 0o123456_654321), zero-wait memory -> mem_read high in cycle 1 only; p0_ack in cycle 3 with p0_rdata=0o123456654321; p1 outputs stay 0.
- Port 1 write of 0o777777_000000 to 0o000200, then port 0 read of 0o000200 -> p1_ack in cycle 2; the read returns 0o777777000000.
- Both ports hold reads continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; each ack 4 cycles apart; no port is starved.
- Memory holds read_ack low for 10 cycles, TIMEOUT=64 -> mem_read high for 11 cycles; ack in the 11th REQ cycle; p1_ack with p1_nxm=0 two cycles later.
- TIMEOUT=8, read_ack never rises -> mem_read high for 8 cycles; p0_ack and p0_nxm=1 in the next cycle with p0_rdata=0; the arbiter returns to IDLE and serves the next request.

Source files
------------

// File: rtl/mem_arb.sv
// Two-port round-robin arbiter in front of a single memory request interface.
// One transaction at a time; optional ack timeout reports non-existent memory.
module mem_arb #(
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 36,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [0:DATA_W-1] p0_wdata,
    input  logic              p0_read,
    input  logic              p0_write,
    output logic [0:DATA_W-1] p0_rdata,
    output logic              p0_ack,
    output logic              p0_nxm,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [0:DATA_W-1] p1_wdata,
    input  logic              p1_read,
    input  logic              p1_write,
    output logic [0:DATA_W-1] p1_rdata,
    output logic              p1_ack,
    output logic              p1_nxm,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [0:DATA_W-1] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [0:DATA_W-1] mem_read_data,
    input  logic              read_ack,
    input  logic              write_ack
);

    typedef enum logic [1:0] {IDLE, REQ, RDATA, ACK} state_t;

    localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t      state;
    logic        gnt;
    logic        favour;
    logic        op_read;
    logic [7:0]  tcnt;

    logic              req0, req1, pick, sel_read, mem_ack, expired;
    logic [ADDR_W-1:0] sel_addr;
    logic [0:DATA_W-1] sel_wdata;

    assign req0      = p0_read | p0_write;
    assign req1      = p1_read | p1_write;
    // On a tie the favoured port wins; with a single requester it simply gets the grant.
    assign pick      = (req0 && req1) ? favour : req1;
    assign sel_read  = pick ? p1_read  : p0_read;
    assign sel_addr  = pick ? p1_addr  : p0_addr;
    assign sel_wdata = pick ? p1_wdata : p0_wdata;
    assign mem_ack   = op_read ? read_ack : write_ack;
    assign expired   = (TIMEOUT != 0) && (tcnt == TO_LAST) && !mem_ack;

    // NOTE: every register here is state, so all assignments are non-blocking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            gnt            <= 1'b0;
            favour         <= 1'b0;
            op_read        <= 1'b0;
            tcnt           <= 8'd0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            p0_rdata       <= '0;
            p1_rdata       <= '0;
            p0_ack         <= 1'b0;
            p1_ack         <= 1'b0;
            p0_nxm         <= 1'b0;
            p1_nxm         <= 1'b0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            p0_nxm <= 1'b0;
            p1_nxm <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt            <= pick;
                        favour         <= ~pick;
                        op_read        <= sel_read;
                        mem_addr       <= sel_addr;
                        mem_write_data <= sel_wdata;
                        mem_read       <= sel_read;
                        mem_write      <= ~sel_read;
                        tcnt           <= 8'd0;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (op_read) begin
                            state <= RDATA;
                        end else begin
                            state <= ACK;
                            if (gnt) p1_ack <= 1'b1;
                            else     p0_ack <= 1'b1;
                        end
                    end else if (expired) begin
                        // Nobody answered: finish with NXM and a zeroed read word.
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= ACK;
                        if (gnt) begin
                            p1_ack <= 1'b1;
                            p1_nxm <= 1'b1;
                            if (op_read) p1_rdata <= '0;
                        end else begin
                            p0_ack <= 1'b1;
                            p0_nxm <= 1'b1;
                            if (op_read) p0_rdata <= '0;
                        end
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                RDATA: begin
                    state <= ACK;
                    if (gnt) begin
                        p1_rdata <= mem_read_data;
                        p1_ack   <= 1'b1;
                    end else begin
                        p0_rdata <= mem_read_data;
                        p0_ack   <= 1'b1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: a zero/variable-wait memory instance (TIMEOUT=64)
// and a second instance (TIMEOUT=8) whose read ack can be withheld.
module tb_mem_arb;

    logic        clk;
    logic        reset;
    logic [21:0] p0_addr, p1_addr;
    logic [0:35] p0_wdata, p1_wdata;
    logic        p0_read, p0_write, p1_read, p1_write;
    logic [0:35] p0_rdata, p1_rdata;
    logic        p0_ack, p0_nxm, p1_ack, p1_nxm;
    logic [21:0] mem_addr;
    logic [0:35] mem_write_data, mem_read_data;
    logic        mem_read, mem_write, read_ack, write_ack;

    logic        t_p0_read, t_p0_write, t_p1_read, t_p1_write;
    logic [0:35] t_p0_rdata, t_p1_rdata;
    logic        t_p0_ack, t_p0_nxm, t_p1_ack, t_p1_nxm;
    logic [21:0] t_mem_addr;
    logic [0:35] t_mem_write_data, t_mem_read_data;
    logic        t_mem_read, t_mem_write, t_read_ack, t_write_ack;
    logic        t_ack_en;

    int checks = 0;
    int errors = 0;

    logic [0:35] mem [0:1023];
    int          ack_delay;
    int          wait_cnt;

    mem_arb #(.ADDR_W(22), .DATA_W(36), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_read(p0_read), .p0_write(p0_write),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_nxm(p0_nxm),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_read(p1_read), .p1_write(p1_write),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_nxm(p1_nxm),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
        .read_ack(read_ack), .write_ack(write_ack)
    );

    mem_arb #(.ADDR_W(22), .DATA_W(36), .TIMEOUT(8)) dut8 (
        .clk(clk), .reset(reset),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_read(t_p0_read), .p0_write(t_p0_write),
        .p0_rdata(t_p0_rdata), .p0_ack(t_p0_ack), .p0_nxm(t_p0_nxm),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_read(t_p1_read), .p1_write(t_p1_write),
        .p1_rdata(t_p1_rdata), .p1_ack(t_p1_ack), .p1_nxm(t_p1_nxm),
        .mem_addr(t_mem_addr), .mem_write_data(t_mem_write_data),
        .mem_read(t_mem_read), .mem_write(t_mem_write), .mem_read_data(t_mem_read_data),
        .read_ack(t_read_ack), .write_ack(t_write_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks are combinational, read data arrives one cycle after the ack.
    assign read_ack        = mem_read && (wait_cnt >= ack_delay);
    assign write_ack       = mem_write;
    assign t_read_ack      = t_mem_read && t_ack_en;
    assign t_write_ack     = t_mem_write;
    assign t_mem_read_data = 36'o555555555555;

    always @(posedge clk) begin
        if (mem_read && !read_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
        if (mem_read && read_ack)   mem_read_data <= mem[mem_addr[9:0]];
        if (mem_write && write_ack) mem[mem_addr[9:0]] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0o exp=%0o", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the cycle (relative to the current one) in which the chosen ack fires.
    task automatic wait_ack(input int which, input string tag, output int n);
        logic seen;
        seen = 1'b0;
        n = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            tick();
            case (which)
                0:       seen = p0_ack;
                1:       seen = p1_ack;
                default: seen = t_p0_ack;
            endcase
            if (seen) n = c;
        end
        if (!seen) check({tag, "_ack_timeout"}, 64'(0), 64'(1));
    endtask

    initial begin
        int n;
        int last;
        int nack;
        reset = 1'b0;
        p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
        p0_read = 0; p0_write = 0; p1_read = 0; p1_write = 0;
        t_p0_read = 0; t_p0_write = 0; t_p1_read = 0; t_p1_write = 0;
        t_ack_en = 1'b1;
        ack_delay = 0;
        wait_cnt = 0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'o100]  = 36'o123456654321;
        mem[10'o1000] = 36'o000111222333;
        mem_read_data = '0;

        tick(); tick();
        check("rst_mem_read",  64'(mem_read), 64'(0));
        check("rst_mem_write", 64'(mem_write), 64'(0));
        check("rst_mem_addr",  64'(mem_addr), 64'(0));
        check("rst_p0_ack",    64'(p0_ack), 64'(0));
        check("rst_p0_rdata",  64'(p0_rdata), 64'(0));
        reset = 1'b1;
        tick();

        // Reset while a read is stuck in REQ.
        ack_delay = 100;
        p0_addr = 22'o001000; p0_read = 1;
        tick();
        check("mid_mem_read_up", 64'(mem_read), 64'(1));
        tick();
        #2 reset = 1'b0;
        #1 check("mid_mem_read_drop", 64'(mem_read), 64'(0));
        @(posedge clk); #1;
        check("mid_no_ack", 64'(p0_ack), 64'(0));
        reset = 1'b1;
        ack_delay = 0;
        wait_ack(0, "mid_fresh", n);
        check("mid_fresh_lat",   64'(n), 64'(3));
        check("mid_fresh_rdata", 64'(p0_rdata), 64'(36'o000111222333));
        p0_read = 0;
        tick();

        // Port 0 read, zero-wait memory, exact cycle positions.
        p0_addr = 22'o000100; p0_read = 1;
        tick();
        check("rd_c1_mem_read", 64'(mem_read), 64'(1));
        check("rd_c1_mem_addr", 64'(mem_addr), 64'(22'o000100));
        check("rd_c1_mem_write", 64'(mem_write), 64'(0));
        tick();
        check("rd_c2_mem_read", 64'(mem_read), 64'(0));
        check("rd_c2_p0_ack",   64'(p0_ack), 64'(0));
        tick();
        check("rd_c3_p0_ack",   64'(p0_ack), 64'(1));
        check("rd_c3_p0_rdata", 64'(p0_rdata), 64'(36'o123456654321));
        check("rd_c3_p0_nxm",   64'(p0_nxm), 64'(0));
        check("rd_c3_p1_ack",   64'(p1_ack), 64'(0));
        check("rd_c3_p1_rdata", 64'(p1_rdata), 64'(0));
        p0_read = 0;
        tick();
        check("rd_c4_p0_ack", 64'(p0_ack), 64'(0));

        // Port 1 write, then port 0 reads it back.
        p1_addr = 22'o000200; p1_wdata = 36'o777777000000; p1_write = 1;
        tick();
        check("wr_c1_mem_write", 64'(mem_write), 64'(1));
        check("wr_c1_mem_read",  64'(mem_read), 64'(0));
        check("wr_c1_wdata",     64'(mem_write_data), 64'(36'o777777000000));
        tick();
        check("wr_c2_p1_ack",    64'(p1_ack), 64'(1));
        check("wr_c2_mem_write", 64'(mem_write), 64'(0));
        check("wr_c2_p0_ack",    64'(p0_ack), 64'(0));
        p1_write = 0;
        tick();
        p0_addr = 22'o000200; p0_read = 1;
        wait_ack(0, "wb", n);
        check("wb_rdata",    64'(p0_rdata), 64'(36'o777777000000));
        check("wb_p1_rdata", 64'(p1_rdata), 64'(0));
        p0_read = 0;
        tick();
        // Port 1 read so port 1 is the last grant before the contention run.
        p1_addr = 22'o000200; p1_read = 1;
        wait_ack(1, "p1rd", n);
        check("p1rd_rdata", 64'(p1_rdata), 64'(36'o777777000000));
        p1_read = 0;
        tick();

        // Both ports requesting continuously: strict alternation, 4 cycles apart.
        p0_addr = 22'o000100; p1_addr = 22'o000200;
        p0_read = 1; p1_read = 1;
        last = 0; nack = 0;
        for (int c = 1; c <= 40 && nack < 6; c++) begin
            tick();
            if (p0_ack || p1_ack) begin
                check("alt_port", 64'(p1_ack), 64'(nack % 2));
                if (nack == 0) check("alt_first", 64'(c), 64'(3));
                else           check("alt_gap", 64'(c - last), 64'(4));
                if (nack % 2 == 1) check("alt_p1_rdata", 64'(p1_rdata), 64'(36'o777777000000));
                else               check("alt_p0_rdata", 64'(p0_rdata), 64'(36'o123456654321));
                last = c;
                nack++;
                if (nack == 6) begin
                    p0_read = 0; p1_read = 0;
                end
            end
        end
        check("alt_count", 64'(nack), 64'(6));
        tick();

        // Slow memory: ack withheld for 10 REQ cycles.
        ack_delay = 10;
        p1_addr = 22'o000100; p1_read = 1;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (!mem_read) break;
            n++;
        end
        check("slow_req_cycles", 64'(n), 64'(11));
        check("slow_c12_p1_ack", 64'(p1_ack), 64'(0));
        tick();
        check("slow_p1_ack",   64'(p1_ack), 64'(1));
        check("slow_p1_nxm",   64'(p1_nxm), 64'(0));
        check("slow_p1_rdata", 64'(p1_rdata), 64'(36'o123456654321));
        p1_read = 0;
        ack_delay = 0;
        tick();

        // TIMEOUT=8 instance: one good read, then a read that is never acked.
        p0_addr = 22'o000300;
        t_p0_read = 1;
        wait_ack(2, "t8_good", n);
        check("t8_good_rdata", 64'(t_p0_rdata), 64'(36'o555555555555));
        check("t8_good_nxm",   64'(t_p0_nxm), 64'(0));
        t_p0_read = 0;
        tick();
        t_ack_en = 1'b0;
        t_p0_read = 1;
        n = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (!t_mem_read) break;
            n++;
        end
        check("t8_req_cycles", 64'(n), 64'(8));
        check("t8_nxm_ack",    64'(t_p0_ack), 64'(1));
        check("t8_nxm",        64'(t_p0_nxm), 64'(1));
        check("t8_nxm_rdata",  64'(t_p0_rdata), 64'(0));
        check("t8_p1_ack",     64'(t_p1_ack), 64'(0));
        check("t8_p1_rdata",   64'(t_p1_rdata), 64'(0));
        t_p0_read = 0;
        tick();
        check("t8_ack_drop", 64'(t_p0_ack), 64'(0));
        check("t8_nxm_drop", 64'(t_p0_nxm), 64'(0));
        p1_addr = 22'o000400; p1_wdata = 36'o000000777777; t_p1_write = 1;
        tick();
        check("t8_wr_mem_write", 64'(t_mem_write), 64'(1));
        check("t8_wr_mem_addr",  64'(t_mem_addr), 64'(22'o000400));
        check("t8_wr_wdata",     64'(t_mem_write_data), 64'(36'o000000777777));
        tick();
        check("t8_wr_p1_ack", 64'(t_p1_ack), 64'(1));
        check("t8_wr_p1_nxm", 64'(t_p1_nxm), 64'(0));
        t_p1_write = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
